// File: rtl/volladdierer_pkg.sv
// Shared constants for the volladdierer ripple-carry adder slice.
// Used by volladdierer; the optional overflow flag is enabled by VOLLADDIERER_OVF_EN.
package volladdierer_pkg;

    // Reset values of the registered outputs.
    localparam logic RST_SUMME     = 1'b0;
    localparam logic RST_UEBERTRAG = 1'b0;
    localparam logic RST_UEBERLAUF = 1'b0;

    // Width of the full result {carry, sum}.
    function automatic int unsigned res_width(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/volladdierer_zelle.sv
// One-bit full-adder cell: one stage of the volladdierer ripple chain.
module volladdierer_zelle (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/volladdierer.sv
// WIDTH-bit ripple-carry full adder with combinational and registered, valid-qualified results.
// Define VOLLADDIERER_OVF_EN to add the signed-overflow outputs ueberlauf/ueberlauf_q.
module volladdierer
    import volladdierer_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s1,
    input  logic [WIDTH-1:0] s2,
    input  logic             s3,
    input  logic             in_valid,
    output logic [WIDTH-1:0] summe,
    output logic             uebertrag,
    output logic [WIDTH-1:0] summe_q,
    output logic             uebertrag_q,
    output logic             out_valid
`ifdef VOLLADDIERER_OVF_EN
    ,
    output logic             ueberlauf,
    output logic             ueberlauf_q
`endif
);

    localparam int unsigned RW = res_width(WIDTH);

    // c[i] is the carry into cell i; c[0] is the external carry-in.
    logic [RW-1:0] c;

    assign c[0] = s3;

    for (genvar i = 0; i < WIDTH; i++) begin : g_zelle
        volladdierer_zelle u_zelle (
            .a    (s1[i]),
            .b    (s2[i]),
            .cin  (c[i]),
            .s    (summe[i]),
            .cout (c[i+1])
        );
    end

    assign uebertrag = c[WIDTH];

`ifdef VOLLADDIERER_OVF_EN
    // Carry into and out of the sign bit disagree exactly on signed overflow.
    assign ueberlauf = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ueberlauf_q <= RST_UEBERLAUF;
        end else if (in_valid) begin
            ueberlauf_q <= ueberlauf;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            summe_q     <= {WIDTH{RST_SUMME}};
            uebertrag_q <= RST_UEBERTRAG;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                summe_q     <= summe;
                uebertrag_q <= uebertrag;
            end
        end
    end

endmodule

// File: tb/tb_volladdierer.sv
// Self-checking bench for volladdierer at WIDTH 1, 8 and 16 against an arithmetic reference.
module tb_volladdierer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // WIDTH=1 instance
    logic a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic sum1, cy1, sum1_q, cy1_q, ov1;
    // WIDTH=8 instance
    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0;
    logic [7:0] sum8, sum8_q;
    logic       cy8, cy8_q, ov8;
    // WIDTH=16 instance
    logic [15:0] a16 = '0, b16 = '0;
    logic        c16 = 1'b0;
    logic [15:0] sum16, sum16_q;
    logic        cy16, cy16_q, ov16;

`ifdef VOLLADDIERER_OVF_EN
    logic ue1, ue1_q, ue8, ue8_q, ue16, ue16_q;
`endif

    volladdierer #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s1(a1), .s2(b1), .s3(c1), .in_valid(in_valid),
        .summe(sum1), .uebertrag(cy1), .summe_q(sum1_q), .uebertrag_q(cy1_q), .out_valid(ov1)
`ifdef VOLLADDIERER_OVF_EN
        , .ueberlauf(ue1), .ueberlauf_q(ue1_q)
`endif
    );

    volladdierer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .s1(a8), .s2(b8), .s3(c8), .in_valid(in_valid),
        .summe(sum8), .uebertrag(cy8), .summe_q(sum8_q), .uebertrag_q(cy8_q), .out_valid(ov8)
`ifdef VOLLADDIERER_OVF_EN
        , .ueberlauf(ue8), .ueberlauf_q(ue8_q)
`endif
    );

    volladdierer #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .s1(a16), .s2(b16), .s3(c16), .in_valid(in_valid),
        .summe(sum16), .uebertrag(cy16), .summe_q(sum16_q), .uebertrag_q(cy16_q), .out_valid(ov16)
`ifdef VOLLADDIERER_OVF_EN
        , .ueberlauf(ue16), .ueberlauf_q(ue16_q)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: signed overflow when both operands share a sign the result does not.
    function automatic logic ref_ovf(input int unsigned w, input longint unsigned a,
                                     input longint unsigned b, input longint unsigned s);
        logic sa, sb, ss;
        sa = a[w-1];
        sb = b[w-1];
        ss = s[w-1];
        return (sa == sb) && (ss != sa);
    endfunction

    initial begin
        logic [1:0]  tab1 [8];
        longint unsigned ref_sum;
        longint unsigned exp_q;
        logic            exp_cy_q;
        logic            exp_v;
        longint unsigned pend;

        tab1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11}; // {uebertrag,summe}

        // Reset state
        #3;
        check("rst_summe_q", 64'(sum8_q), 64'h0);
        check("rst_uebertrag_q", 64'(cy8_q), 64'h0);
        check("rst_out_valid", 64'(ov8), 64'h0);

        // WIDTH=1 exhaustive truth table
        for (int unsigned v = 0; v < 8; v++) begin
            {a1, b1, c1} = 3'(v);
            #10;
            check($sformatf("w1_%0d", v), 64'({cy1, sum1}), 64'(tab1[v]));
`ifdef VOLLADDIERER_OVF_EN
            check($sformatf("w1_ovf_%0d", v), 64'(ue1), 64'((cy1 === 1'bx) ? 1'b0 : (tab1[v][1] ^ c1)));
`endif
        end

        // WIDTH=8 directed boundaries
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; #1;
        check("w8_ff_00_1", 64'({cy8, sum8}), 64'h100);
        a8 = 8'h3C; b8 = 8'h05; c8 = 1'b0; #1;
        check("w8_3c_05_0", 64'({cy8, sum8}), 64'h041);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; #1;
        check("w8_allones", 64'({cy8, sum8}), 64'h1FF);
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; #1;
        check("w8_allzeros", 64'({cy8, sum8}), 64'h000);
`ifdef VOLLADDIERER_OVF_EN
        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; #1;
        check("ovf_7f_01", 64'({ue8, cy8, sum8}), 64'h280);
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; #1;
        check("ovf_ff_01", 64'({ue8, cy8}), 64'h1);
`endif

        // Leave reset away from a clock edge, then capture 80+80+1
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h80; b8 = 8'h80; c8 = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        check("reg_summe_q", 64'(sum8_q), 64'h01);
        check("reg_uebertrag_q", 64'(cy8_q), 64'h1);
        check("reg_out_valid", 64'(ov8), 64'h1);
`ifdef VOLLADDIERER_OVF_EN
        check("reg_ueberlauf_q", 64'(ue8_q), 64'h1);
`endif
        in_valid = 1'b0;
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
        @(posedge clk); #1;
        check("hold_out_valid", 64'(ov8), 64'h0);
        check("hold_summe_q", 64'(sum8_q), 64'h01);
        check("hold_uebertrag_q", 64'(cy8_q), 64'h1);

        // Async reset between edges while a result is held
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_out_valid", 64'(ov8), 64'h1);
        check("pre_rst_summe_q", 64'(sum8_q), 64'h46);
        #2 rst_n = 1'b0;
        #1;
        check("arst_summe_q", 64'(sum8_q), 64'h0);
        check("arst_uebertrag_q", 64'(cy8_q), 64'h0);
        check("arst_out_valid", 64'(ov8), 64'h0);
        a8 = 8'hA0; b8 = 8'h70; c8 = 1'b1; #1;
        check("arst_comb_tracks", 64'({cy8, sum8}), 64'h111);
        @(posedge clk); #1;
        check("rst_held_out_valid", 64'(ov8), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_capture_valid", 64'(ov8), 64'h1);
        check("first_capture", 64'({cy8_q, sum8_q}), 64'h111);
        in_valid = 1'b0;

        // WIDTH=16 random combinational regression
        for (int unsigned n = 0; n < 10000; n++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom);
            #1;
            ref_sum = longint'(a16) + longint'(b16) + longint'(c16);
            check("rand16_comb", 64'({cy16, sum16}), ref_sum);
`ifdef VOLLADDIERER_OVF_EN
            check("rand16_ovf", 64'(ue16), 64'(ref_ovf(16, longint'(a16), longint'(b16), ref_sum)));
`endif
        end

        // WIDTH=16 random registered path against a capture/hold model
        @(posedge clk); #1;
        exp_q = longint'({cy16_q, sum16_q}) & 64'h1FFFF;
        exp_q = 64'(ov16 ? exp_q : exp_q);
        exp_v = 1'b0;
        exp_cy_q = cy16_q;
        exp_q = 64'({cy16_q, sum16_q});
        for (int unsigned n = 0; n < 300; n++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom);
            in_valid = 1'($urandom);
            pend = longint'(a16) + longint'(b16) + longint'(c16);
            @(posedge clk); #1;
            if (in_valid) begin
                exp_q = pend;
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
            exp_cy_q = exp_q[16];
            check("rand16_valid", 64'(ov16), 64'(exp_v));
            check("rand16_q", 64'({cy16_q, sum16_q}), exp_q);
            check("rand16_cy_q", 64'(cy16_q), 64'(exp_cy_q));
        end
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
